// File: rtl/mul_div_unit_pkg.sv
// Shared types for the RV32M multiply/divide unit and its decoder hook.
package mul_div_unit_pkg;

    localparam logic [6:0] M_EXT_FUNCT7 = 7'b0000001;
    localparam logic [6:0] OP_R_TYPE    = 7'b0110011;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_type;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_CALC,
        MD_FIX,
        MD_DONE
    } md_state_type;

    typedef struct packed {
        logic reg_write;
        logic alu_src;
        logic is_muldiv;
    } control_type;

    function automatic logic decode_is_muldiv(
        input logic [6:0] opcode,
        input logic [6:0] funct7
    );
        return (opcode == OP_R_TYPE) && (funct7 == M_EXT_FUNCT7);
    endfunction

endpackage

// File: rtl/mul_div_unit_iter_core.sv
// Unsigned radix-2 datapath: shift-add multiply or restoring divide.
module md_iter_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            step,
    input  logic            div,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   m;
    logic              div_q;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     part;
    logic [XLEN:0]     diff;
    logic              fits;

    assign hi = acc[2*XLEN-1:XLEN];
    assign lo = acc[XLEN-1:0];

    // mul: hi accumulates, lo holds the shrinking multiplier
    // div: hi is the partial remainder, lo shifts dividend out / quotient in
    always_comb begin
        mul_sum = {1'b0, hi} + (acc[0] ? {1'b0, m} : '0);
        part    = {hi, acc[XLEN-1]};
        diff    = part - {1'b0, m};
        fits    = ~diff[XLEN];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc   <= '0;
            m     <= '0;
            div_q <= 1'b0;
        end else if (load) begin
            div_q <= div;
            m     <= div ? b : a;
            acc   <= {{XLEN{1'b0}}, (div ? a : b)};
        end else if (step) begin
            if (div_q) begin
                acc <= {(fits ? diff[XLEN-1:0] : part[XLEN-1:0]),
                        acc[XLEN-2:0], fits};
            end else begin
                acc <= {mul_sum, acc[XLEN-1:1]};
            end
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: FSM, sign handling, special cases.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter  int XLEN  = 32,
    localparam int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic [4:0]      rd_id,
    input  logic            flush,
    output logic            busy,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [4:0]      out_rd_id
);

    localparam logic [XLEN-1:0] MIN_S = {1'b1, {(XLEN-1){1'b0}}};

    md_state_type     state;
    logic [CNT_W-1:0] count;
    md_op_type        op_in;
    md_op_type        op_q;
    logic             neg_q;
    logic             neg_rem_q;

    logic             a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0]  a_mag, b_mag;
    logic             special;
    logic [XLEN-1:0]  spec_res;
    logic             accept;
    logic [XLEN-1:0]  hi, lo;
    logic [2*XLEN-1:0] prod_c;
    logic [XLEN-1:0]  quo_c, rem_c, fix_res;

    assign op_in     = md_op_type'(op);
    assign in_ready  = (state == MD_IDLE);
    assign busy      = (state != MD_IDLE);
    assign out_valid = (state == MD_DONE);
    assign accept    = in_valid & in_ready & ~flush;

    always_comb begin
        a_sgn = (op_in == MD_MUL) || (op_in == MD_MULH) ||
                (op_in == MD_MULHSU) || (op_in == MD_DIV) ||
                (op_in == MD_REM);
        b_sgn = (op_in == MD_MUL) || (op_in == MD_MULH) ||
                (op_in == MD_DIV) || (op_in == MD_REM);
        a_neg = a_sgn & operand_a[XLEN-1];
        b_neg = b_sgn & operand_b[XLEN-1];
        a_mag = a_neg ? -operand_a : operand_a;
        b_mag = b_neg ? -operand_b : operand_b;
    end

    // op[2] selects divide, op[1] selects remainder, op[0] unsigned divide
    always_comb begin
        special  = 1'b0;
        spec_res = '0;
        if (op_in[2]) begin
            if (operand_b == '0) begin
                special  = 1'b1;
                spec_res = op_in[1] ? operand_a : '1;
            end else if (!op_in[0] && operand_a == MIN_S &&
                         operand_b == '1) begin
                special  = 1'b1;
                spec_res = op_in[1] ? '0 : operand_a;
            end
        end else if (operand_a == '0 || operand_b == '0) begin
            special = 1'b1;
        end
    end

    md_iter_core #(.XLEN(XLEN)) u_core (
        .clk   (clk),
        .reset (reset),
        .load  (accept & ~special),
        .step  (state == MD_CALC),
        .div   (op_in[2]),
        .a     (a_mag),
        .b     (b_mag),
        .hi    (hi),
        .lo    (lo)
    );

    always_comb begin
        prod_c  = neg_q ? -{hi, lo} : {hi, lo};
        quo_c   = neg_q ? -lo : lo;
        rem_c   = neg_rem_q ? -hi : hi;
        fix_res = '0;
        case (op_q)
            MD_MUL:                       fix_res = prod_c[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: fix_res = prod_c[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              fix_res = quo_c;
            default:                      fix_res = rem_c;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= MD_IDLE;
            count     <= '0;
            op_q      <= MD_MUL;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            result    <= '0;
            out_rd_id <= '0;
        end else if (flush) begin
            state <= MD_IDLE;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (in_valid) begin
                        op_q      <= op_in;
                        neg_q     <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        out_rd_id <= rd_id;
                        if (special) begin
                            result <= spec_res;
                            state  <= MD_DONE;
                        end else begin
                            count <= CNT_W'(XLEN);
                            state <= MD_CALC;
                        end
                    end
                end
                MD_CALC: begin
                    count <= count - 1'b1;
                    if (count == CNT_W'(1)) state <= MD_FIX;
                end
                MD_FIX: begin
                    result <= fix_res;
                    state  <= MD_DONE;
                end
                default: begin
                    if (out_ready) state <= MD_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit at XLEN=32.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    localparam int NORM_LAT = 34;
    localparam int SPEC_LAT = 1;
    localparam int TMO      = 100;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [4:0]  rd_id;
    logic        flush;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [4:0]  out_rd_id;

    int checks;
    int errors;

    mul_div_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .rd_id     (rd_id),
        .flush     (flush),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .out_rd_id (out_rd_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one op for a single edge, then scrambles the operand bus.
    task automatic issue(input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        in_valid  = 1'b1;
        op        = o;
        operand_a = a;
        operand_b = b;
        rd_id     = rd;
        tick();
        in_valid  = 1'b0;
        operand_a = $urandom;
        operand_b = $urandom;
        rd_id     = 5'($urandom);
    endtask

    // Latency in cycles, counting the accept cycle as N; TMO on timeout.
    task automatic wait_valid(output int lat);
        int n;
        n = 0;
        while (!out_valid && n < TMO) begin
            tick();
            n++;
        end
        lat = out_valid ? n + 1 : TMO;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if ({in_ready, busy, out_valid} !== 3'b100 ||
            result !== 32'h0 || out_rd_id !== 5'h0) begin
            errors++;
            $display("FAIL reset: rdy/busy/vld=%b res=%h rd=%h want 100/0/0",
                     {in_ready, busy, out_valid}, result, out_rd_id);
        end
    endtask

    task automatic test_mul();
        int lat;
        logic [2:0]  ops [3]  = '{MD_MULH, MD_MULHU, MD_MULHSU};
        logic [31:0] av  [3]  = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] bv  [3]  = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] ex  [3]  = '{32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF};
        issue(MD_MUL, 32'd7, 32'hFFFFFFFD, 5'd5);
        wait_valid(lat);
        checks++;
        if (lat != NORM_LAT) begin
            errors++;
            $display("FAIL mul_latency: got %0d want %0d", lat, NORM_LAT);
        end
        checks++;
        if (result !== 32'hFFFFFFEB || out_rd_id !== 5'd5) begin
            errors++;
            $display("FAIL mul: res=%h rd=%0d want FFFFFFEB rd=5",
                     result, out_rd_id);
        end
        consume();
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], av[i], bv[i], 5'(i + 1));
            wait_valid(lat);
            checks++;
            if (lat != NORM_LAT || result !== ex[i]) begin
                errors++;
                $display("FAIL mulh_%0d: res=%h lat=%0d want %h lat=%0d",
                         i, result, lat, ex[i], NORM_LAT);
            end
            consume();
        end
    endtask

    task automatic test_div();
        int lat;
        logic [2:0]  ops [4] = '{MD_DIV, MD_REM, MD_DIVU, MD_REMU};
        logic [31:0] av  [4] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
        logic [31:0] bv  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] ex  [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], av[i], bv[i], 5'(10 + i));
            wait_valid(lat);
            checks++;
            if (lat != NORM_LAT || result !== ex[i] ||
                out_rd_id !== 5'(10 + i)) begin
                errors++;
                $display("FAIL div_%0d: res=%h lat=%0d rd=%0d want %h lat=%0d",
                         i, result, lat, out_rd_id, ex[i], NORM_LAT);
            end
            consume();
        end
    endtask

    task automatic test_special();
        int lat;
        logic [2:0]  ops [5] = '{MD_DIVU, MD_REM, MD_DIV, MD_REM, MD_MUL};
        logic [31:0] av  [5] = '{32'h1234, 32'h1234, 32'h80000000,
                                 32'h80000000, 32'h0};
        logic [31:0] bv  [5] = '{32'h0, 32'h0, 32'hFFFFFFFF,
                                 32'hFFFFFFFF, 32'h12345};
        logic [31:0] ex  [5] = '{32'hFFFFFFFF, 32'h1234, 32'h80000000,
                                 32'h0, 32'h0};
        for (int i = 0; i < 5; i++) begin
            issue(ops[i], av[i], bv[i], 5'(20 + i));
            wait_valid(lat);
            checks++;
            if (lat != SPEC_LAT || result !== ex[i]) begin
                errors++;
                $display("FAIL special_%0d: res=%h lat=%0d want %h lat=%0d",
                         i, result, lat, ex[i], SPEC_LAT);
            end
            consume();
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        issue(MD_DIVU, 32'd100, 32'd7, 5'd9);
        wait_valid(lat);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            op       = MD_MUL;
            tick();
            checks++;
            if (out_valid !== 1'b1 || result !== 32'd14 ||
                in_ready !== 1'b0 || out_rd_id !== 5'd9) begin
                errors++;
                $display("FAIL hold_%0d: vld=%b res=%h rdy=%b want 1/0000000e/0",
                         i, out_valid, result, in_ready);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL done_ready: in_ready=%b want 0", in_ready);
        end
        tick();
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL release: rdy=%b vld=%b busy=%b want 1/0/0",
                     in_ready, out_valid, busy);
        end
    endtask

    task automatic test_flush();
        int lat;
        logic seen;
        seen = 1'b0;
        issue(MD_DIV, 32'd1000, 32'd3, 5'd3);
        for (int i = 0; i < 9; i++) begin
            seen |= out_valid;
            tick();
        end
        flush    = 1'b1;
        in_valid = 1'b1;
        op       = MD_MUL;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (seen || busy !== 1'b0 || in_ready !== 1'b1 ||
            out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush: seen=%b busy=%b rdy=%b vld=%b want 0/0/1/0",
                     seen, busy, in_ready, out_valid);
        end
        issue(MD_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd17);
        wait_valid(lat);
        checks++;
        if (lat != NORM_LAT || result !== 32'hFFFFFFFE ||
            out_rd_id !== 5'd17) begin
            errors++;
            $display("FAIL after_flush: res=%h lat=%0d rd=%0d want fffffffe/%0d/17",
                     result, lat, out_rd_id, NORM_LAT);
        end
        consume();
        flush     = 1'b1;
        in_valid  = 1'b1;
        op        = MD_DIVU;
        operand_a = 32'd50;
        operand_b = 32'd5;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_idle: busy=%b rdy=%b want 0/1",
                     busy, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        issue(MD_MULHU, 32'hFFFFFFFF, 32'h2, 5'd30);
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({in_ready, busy, out_valid} !== 3'b100 ||
            result !== 32'h0 || out_rd_id !== 5'h0) begin
            errors++;
            $display("FAIL reset_mid: rdy/busy/vld=%b res=%h rd=%h want 100/0/0",
                     {in_ready, busy, out_valid}, result, out_rd_id);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        op        = 3'b000;
        operand_a = '0;
        operand_b = '0;
        rd_id     = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative RV32M multiply/divide execution unit, parametrised in data width (XLEN).
- Sits in EX beside the single-cycle ALU.
- Accepts one M-extension op (funct7 = 0000001) through a valid/ready handshake, computes over multiple cycles, and returns a registered result with its destination register tag.
- The hazard unit stalls IF/ID/EX while the unit is busy; branch redirects abort an in-flight op through flush.

Parameters:
- XLEN, 32, operand and result width (must be even, ≥ 8).
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived; not overridden).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  op present on op/operand_a/operand_b/rd_id
- in_ready  out  1  unit can accept; high only in IDLE
- op  in  3  md_op_type (= funct3): MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
- operand_a  in  XLEN  rs1 value (forwarded)
- operand_b  in  XLEN  rs2 value (forwarded)
- rd_id  in  5  destination register tag
- flush  in  1  abort in-flight op
- busy  out  1  state != IDLE
- out_valid  out  1  result valid
- out_ready  in  1  consumer (MEM stage) accepts result
- result  out  XLEN  result
- out_rd_id  out  5  tag of the result

Behaviour:
- All state is updated on posedge clk. Reset and flush have priority over every other event.
- Reset → state IDLE; in_ready=1, busy=0, out_valid=0, result=0, out_rd_id=0, counter=0.
- Accept: in_valid & in_ready & !flush. Op, operand magnitudes, sign flags, and rd_id are latched.
- States:
  - IDLE: on accept go to CALC (counter=XLEN), or to DONE directly for a special case.
  - CALC: one radix-2 step per cycle, counter decrements; at counter==1 go to FIX.
  - FIX: apply sign correction, select result half; go to DONE.
  - DONE: out_valid=1; hold result and out_rd_id until out_ready; then go to IDLE.
- Latency, accept cycle N:
  - Normal ops: out_valid first high at N+XLEN+2.
  - Special cases: out_valid first high at N+1.
- No back-to-back accept: in_ready is low in DONE even when out_ready is high.
- Multiply:
  - Shift-add on magnitudes into a 2·XLEN product.
  - Operand signedness: MUL and MULH treat both operands as signed; MULHSU treats a as signed, b as unsigned; MULHU treats both as unsigned.
  - Product negated in FIX when exactly one signed-treated operand is negative.
  - MUL returns product[XLEN-1:0]; MULH* return product[2XLEN-1:XLEN].
- Divide:
  - Restoring division on magnitudes.
  - Quotient negated if signs of a and b differ (signed ops).
  - Remainder takes the sign of a.
- Special cases (detected at accept, skip CALC/FIX):
  - b==0: DIV/DIVU → all-ones; REM/REMU → a.
  - Signed overflow (a == min signed, b == −1): DIV → a; REM → 0.
  - MUL-family with a==0 or b==0 → 0.
- Flush:
  - In any state, the next state is IDLE and out_valid=0 from the next cycle.
  - A flush coinciding with in_valid in IDLE is not accepted.
  - A flush coinciding with out_valid&out_ready: the result counts as consumed (handshake completes), then IDLE.
- Reset mid-CALC: same as flush; all outputs return to their reset values.
- Inputs are ignored outside IDLE; operands may change freely after accept.

Decomposition:
- Package common gains:
  - md_op_type enum (3 bits, MD_MUL=3'b000 … MD_REMU=3'b111, matching funct3).
  - localparam M_EXT_FUNCT7 = 7'b0000001.
  - md_state_type enum {MD_IDLE, MD_CALC, MD_FIX, MD_DONE}.
- Control_type gains an is_muldiv bit; the decoder sets it for R_type with funct7 = M_EXT_FUNCT7.
- Sub-module md_iter_core: unsigned shift-add/restoring-divide datapath with step/load inputs.
- The top level holds the FSM, sign handling, special-case detection, and the handshake.

Test Plan (XLEN=32):
- MUL a=7, b=0xFFFFFFFD (−3): accept at cycle N → out_valid at N+34, result 0xFFFFFFEB; out_rd_id echoes rd_id.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (−7), b=2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIVU a=0x1234, b=0 → 0xFFFFFFFF at N+1; REM same operands → 0x1234; DIV 0x80000000/0xFFFFFFFF → 0x80000000 at N+1, REM → 0.
- Hold out_ready=0 for 5 cycles in DONE → out_valid and result stable, in_ready=0; raise out_ready → IDLE next cycle, in_ready=1.
- Flush at N+10 of a DIV → IDLE at N+11, out_valid never asserted. A new op accepted at N+11 completes correctly. Reset pulse mid-CALC → all outputs at reset values.
